// File: rtl/gate_activation_pipe_if.sv
// Stream bundle for gate_activation_pipe: pre-activation words in, activations out.
// A word moves on a cycle where valid & ready are both high; the producer keeps valid and payload stable until then.
interface gate_activation_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_func;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_sat;
  logic [CNT_WIDTH-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_func, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_data, in_func, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sat, out_count
  );
endinterface

// File: rtl/gate_activation_pipe.sv
// Two-stage elastic pipeline applying hard sigmoid / hard tanh / identity / ReLU
// to signed fixed-point gate pre-activations, with tag pass-through and transfer counter.
module gate_activation_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int TAG_WIDTH   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input logic                clk,
  input logic                rst,
  gate_activation_pipe_if.slave bus
);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic signed [EW-1:0] ONE_E  = EW'(1) << FRACT_WIDTH;
  localparam logic signed [EW-1:0] HALF_E = ONE_E >>> 1;
  localparam logic [DATA_WIDTH-1:0] ONE_D     = ONE_E[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] NEG_ONE_D = DATA_WIDTH'(-ONE_E);

  typedef enum logic [1:0] {
    FN_SIGMOID = 2'd0,
    FN_TANH    = 2'd1,
    FN_IDENT   = 2'd2,
    FN_RELU    = 2'd3
  } func_e;

  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_data;
  func_e                        s1_func;
  logic [TAG_WIDTH-1:0]         s1_tag;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic                  s2_sat;
  logic [CNT_WIDTH-1:0]  count;

  logic s2_adv;
  logic s1_adv;

  // An empty stage or a draining downstream frees a slot in the same cycle.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Widened by two bits so the sigmoid offset and clamp tests cannot overflow.
  logic signed [EW-1:0]  x_e;
  logic signed [EW-1:0]  sig_t;
  logic [DATA_WIDTH-1:0] res;
  logic                  sat;

  assign x_e   = {{2{s1_data[DATA_WIDTH-1]}}, s1_data};
  assign sig_t = (x_e >>> 2) + HALF_E;

  always_comb begin
    res = s1_data;
    sat = 1'b0;
    case (s1_func)
      FN_SIGMOID: begin
        if (sig_t < 0) begin
          res = '0;
          sat = 1'b1;
        end else if (sig_t > ONE_E) begin
          res = ONE_D;
          sat = 1'b1;
        end else begin
          res = sig_t[DATA_WIDTH-1:0];
        end
      end
      FN_TANH: begin
        if (x_e > ONE_E) begin
          res = ONE_D;
          sat = 1'b1;
        end else if (x_e < -ONE_E) begin
          res = NEG_ONE_D;
          sat = 1'b1;
        end
      end
      FN_IDENT: res = s1_data;
      FN_RELU:  res = s1_data[DATA_WIDTH-1] ? '0 : s1_data;
      default:  res = s1_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_func  <= FN_SIGMOID;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_sat   <= 1'b0;
      count    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_func <= func_e'(bus.in_func);
          s1_tag  <= bus.in_tag;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res;
          s2_tag  <= s1_tag;
          s2_sat  <= sat;
        end
      end
      if (s2_valid && bus.out_ready) begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_tag   = s2_tag;
  assign bus.out_sat   = s2_sat;
  assign bus.out_count = count;
endmodule

// File: tb/tb_gate_activation_pipe.sv
// Bench for gate_activation_pipe: directed vectors, backpressure, bubbles, reset and counter wrap.
module tb_gate_activation_pipe;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic rand_ready = 1'b0;
  logic bp_done = 1'b0;

  logic [20:0] exp_q[$];

  gate_activation_pipe_if #(.DATA_WIDTH(16), .TAG_WIDTH(4), .CNT_WIDTH(16)) bus ();
  gate_activation_pipe_if #(.DATA_WIDTH(16), .TAG_WIDTH(4), .CNT_WIDTH(4))  bus_w ();

  gate_activation_pipe #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gate_activation_pipe #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Independent reference: floor division by 4 written out, clamps in plain integers.
  function automatic logic [20:0] model(input logic [15:0] d, input logic [1:0] f, input logic [3:0] t);
    int   x;
    int   q;
    int   r;
    logic s;
    x = int'($signed(d));
    r = x;
    s = 1'b0;
    case (f)
      2'd0: begin
        q = x / 4;
        if (x < 0 && (x % 4) != 0) q = q - 1;
        r = q + 128;
        if (r < 0) begin r = 0; s = 1'b1; end
        else if (r > 256) begin r = 256; s = 1'b1; end
      end
      2'd1: begin
        if (x > 256) begin r = 256; s = 1'b1; end
        else if (x < -256) begin r = -256; s = 1'b1; end
      end
      2'd2: r = x;
      default: if (x < 0) r = 0;
    endcase
    return {t, s, r[15:0]};
  endfunction

  task automatic send(input logic [15:0] d, input logic [1:0] f, input logic [3:0] t, input logic [20:0] e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_func  = f;
    bus.in_tag   = t;
    exp_q.push_back(e);
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 1000) begin
        check("send_timeout", 32'(n), 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 3000) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        break;
      end
    end
    #1;
  endtask

  // Scoreboard monitor: every output transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output got=%0h exp=none", {bus.out_tag, bus.out_sat, bus.out_data});
      end else begin
        check("scoreboard", 32'({bus.out_tag, bus.out_sat, bus.out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [15:0] sig_in  [5] = '{16'h0000, 16'h0100, 16'hFFFD, 16'h0500, 16'hFB00};
  logic [15:0] sig_out [5] = '{16'h0080, 16'h00C0, 16'h007F, 16'h0100, 16'h0000};
  logic        sig_sat [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic [15:0] mix_in  [6] = '{16'h0180, 16'hFF80, 16'hFE00, 16'h8000, 16'hFF00, 16'h0234};
  logic [1:0]  mix_fn  [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [15:0] mix_out [6] = '{16'h0100, 16'hFF80, 16'hFF00, 16'h8000, 16'h0000, 16'h0234};
  logic        mix_sat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_func = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    bus_w.in_valid = 1'b0;
    bus_w.in_data = '0;
    bus_w.in_func = 2'd2;
    bus_w.in_tag = '0;
    bus_w.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 5; i++)
      send(sig_in[i], 2'd0, 4'(i), {4'(i), sig_sat[i], sig_out[i]});
    drain();
    check("sigmoid_count", 32'(bus.out_count), 32'd5);

    for (int i = 0; i < 6; i++)
      send(mix_in[i], mix_fn[i], 4'(i + 8), {4'(i + 8), mix_sat[i], mix_out[i]});
    drain();
    check("mix_count", 32'(bus.out_count), 32'd11);

    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(16'(i * 16), 2'd2, 4'(i), {4'(i), 1'b0, 16'(i * 16)});
        bp_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_tag", 32'(bus.out_tag), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(bus.out_data), 32'h10);
      check("bp_hold_tag", 32'(bus.out_tag), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("bp_no_gap_valid", 32'(bus.out_valid), 32'd1);
      check("bp_order_tag", 32'(bus.out_tag), 32'(i));
    end
    wait (bp_done);
    drain();
    check("bp_count", 32'(bus.out_count), 32'd15);

    bus.out_ready = 1'b0;
    send(16'h0011, 2'd2, 4'd5, {4'd5, 1'b0, 16'h0011});
    send(16'h0022, 2'd2, 4'd6, {4'd6, 1'b0, 16'h0022});
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0777;
    bus.in_tag = 4'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_ghost", 32'(bus.out_valid), 32'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] d;
      logic [1:0]  f;
      d = 16'($urandom_range(0, 65535));
      f = 2'($urandom_range(0, 3));
      send(d, f, 4'(i), model(d, f, 4'(i)));
      @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();
    check("bubble_count", 32'(bus.out_count), 32'd200);

    bus_w.in_valid = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (k == 17) begin
        bus_w.in_valid = 1'b0;
        check("wrap_count_15", 32'(bus_w.out_count), 32'd15);
      end
      if (k == 18) check("wrap_count_0", 32'(bus_w.out_count), 32'd0);
      if (k == 19) check("wrap_count_1", 32'(bus_w.out_count), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gate_activation_pipe.md
Name: gate_activation_pipe

Overview:
Downstream neighbour of the gate pre-activation stage. It consumes the signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH pre-activation word (W*{x,h}+b) and applies the gate nonlinearity selected per sample: hard sigmoid, hard tanh, identity or ReLU. It is a 2-stage elastic pipeline with valid/ready handshakes, a tag pass-through and a transfer counter. It feeds the GRU/LSTM state-update logic.

Parameters:
DATA_WIDTH, 16, signed data word width
FRACT_WIDTH, 8, fractional bits; ONE = 1<<FRACT_WIDTH, HALF = ONE>>1
TAG_WIDTH, 4, opaque sample tag carried alongside the data
CNT_WIDTH, 16, width of the output transfer counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  block can accept this cycle
in_data  in  DATA_WIDTH  signed pre-activation
in_func  in  2  0=sigmoid, 1=tanh, 2=identity, 3=ReLU
in_tag  in  TAG_WIDTH  sample tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  signed activation result
out_tag  out  TAG_WIDTH  tag of out_data
out_sat  out  1  result was clamped
out_count  out  CNT_WIDTH  number of completed output transfers

Behaviour:
- Single clock. rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_tag=0, out_sat=0, out_count=0, both stage valids=0. in_ready=1 on the first cycle after reset.
- Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready.
- Stage S1 registers data, func and tag. Stage S2 registers the computed result, tag and sat.
- Latency: exactly 2 cycles from input transfer to out_valid with no stall. Throughput is 1 word/cycle.
- Advance rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. A combinational path from out_ready to in_ready is permitted.
- When S2 is stalled (out_valid & !out_ready), out_data/out_tag/out_sat hold stable. S1 holds if it is full.
- No word is dropped or duplicated, and order is preserved. Capacity is 2 words.
- If in_valid is low while the stage advances, the stage valid clears. Data may hold its old value.
- Arithmetic (x = S1 data, computed in DATA_WIDTH+2 signed bits, no intermediate overflow):
  - sigmoid: t = (x >>> 2) + HALF, arithmetic shift (floor). Result = clamp(t, 0, ONE). sat=1 iff t<0 or t>ONE.
  - tanh: result = clamp(x, -ONE, ONE). sat=1 iff clamped.
  - identity: result = x, sat=0.
  - ReLU: result = x<0 ? 0 : x, sat=0.
- out_count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
- rst mid-operation: all in-flight words are discarded, outputs go to reset values the next cycle, and out_count=0. Inputs presented in the reset cycle are ignored.
- in_func/in_tag values are sampled only on an input transfer.

Test Plan:
- Sigmoid, no stall, out_ready=1, inputs 0x0000, 0x0100, 0xFFFD, 0x0500, 0xFB00 on consecutive cycles -> outputs 2 cycles later, one per cycle:
  - 0x0080 sat0
  - 0x00C0 sat0
  - 0x007F sat0
  - 0x0100 sat1
  - 0x0000 sat1
  - out_count ends at 5.
- Tanh/identity/ReLU checks:
  - tanh 0x0180 -> 0x0100 sat1
  - tanh 0xFF80 -> 0xFF80 sat0
  - tanh 0xFE00 -> 0xFF00 sat1
  - identity 0x8000 -> 0x8000 sat0
  - ReLU 0xFF00 -> 0x0000
  - ReLU 0x0234 -> 0x0234
- Backpressure:
  - Hold out_ready=0, drive in_valid=1 with tags 1,2,3,4. Tags 1,2 are accepted, then in_ready=0 and out_data/out_tag (tag 1) stay stable.
  - Release out_ready -> tags emerge 1,2,3,4 in order with no gaps after release and no duplicates.
- Bubbles: alternate in_valid 1/0 with randomly toggled out_ready over 200 words -> the scoreboard matches a reference model exactly and out_count=200.
- Reset mid-operation: with 2 words in flight and out_ready=0, assert rst for 1 cycle -> next cycle out_valid=0, out_count=0, in_ready=1. The stalled words never appear.
- Counter wrap: with CNT_WIDTH=4, complete 17 transfers -> out_count reads 15 then 0 then 1.
